heap_array_index: RTL and testbench

Sequential search engine on the reading side of the heap memory port. Given an array number, a live length and a key, it streams the array's elements out of heap memory one per cycle and reports the 1-based index of the last matching element, or 0 if none matches. It replaces the single-cycle combinational `arrayIndex` scan with a pipelined reader on the synchronous heap read port. It sits between the instruction sequencer (issuer of `start`) and the heap memory.

---
 rtl/heap_pkg.sv | 15 +
 rtl/heap_array_index_if.sv | 28 ++
 rtl/heap_array_index.sv | 106 ++++++++++
 tb/tb_heap_array_index.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared defaults and state type for the heap memory search blocks.
package heap_pkg;

  localparam int unsigned HeapElemWidth = 12;
  localparam int unsigned HeapNArea     = 4;
  localparam int unsigned HeapAddrWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } heap_search_state_t;

endpackage

// File: rtl/heap_array_index_if.sv
// Request, result and heap read-port signals of the array search engine.
interface heap_array_index_if
  import heap_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = HeapElemWidth,
  parameter int unsigned AddressWidth       = HeapAddrWidth
);
  logic                          start;
  logic [MemoryElementWidth-1:0] array;
  logic [MemoryElementWidth-1:0] size;
  logic [MemoryElementWidth-1:0] key;
  logic                          memRead;
  logic [AddressWidth-1:0]       memAddress;
  logic [MemoryElementWidth-1:0] memData;
  logic                          busy;
  logic                          done;
  logic [MemoryElementWidth-1:0] result;

  modport master (
    output start, array, size, key, memData,
    input  memRead, memAddress, busy, done, result
  );

  modport slave (
    input  start, array, size, key, memData,
    output memRead, memAddress, busy, done, result
  );
endinterface

// File: rtl/heap_array_index.sv
// Pipelined search over one heap array: reports 1-based index of the last element equal to key.
module heap_array_index
  import heap_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = HeapElemWidth,
  parameter int unsigned NArea              = HeapNArea,
  parameter int unsigned AddressWidth       = HeapAddrWidth
) (
  input logic               clock,
  input logic               reset,
  heap_array_index_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(NArea + 1);
  typedef logic [CntWidth-1:0] cnt_t;

  heap_search_state_t            state_q, state_d;
  logic [AddressWidth-1:0]       addr_q, addr_d;
  cnt_t                          n_q, n_d;
  cnt_t                          k_q, k_d;
  cnt_t                          idx_q, idx_d;
  logic                          vld_q, vld_d;
  logic [MemoryElementWidth-1:0] key_q, key_d;
  logic [MemoryElementWidth-1:0] result_q, result_d;
  cnt_t                          size_clamp;

  always_comb begin
    size_clamp = (bus.size > MemoryElementWidth'(NArea)) ? cnt_t'(NArea) : cnt_t'(bus.size);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    n_d      = n_q;
    k_d      = k_q;
    idx_d    = idx_q;
    vld_d    = 1'b0;
    key_d    = key_q;
    result_d = result_q;

    // Compare stage: heap data for the read issued last cycle arrives now.
    if (vld_q && (bus.memData == key_q)) begin
      result_d = MemoryElementWidth'(idx_q);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          key_d    = bus.key;
          k_d      = size_clamp;
          n_d      = '0;
          result_d = '0;
          if (size_clamp == '0) begin
            state_d = StDone;
          end else begin
            // Address only moves when a read will follow, so it holds for empty searches.
            addr_d  = AddressWidth'(bus.array * NArea);
            state_d = StRead;
          end
        end
      end
      StRead: begin
        vld_d = 1'b1;
        idx_d = n_q + cnt_t'(1);
        if (n_q == k_q - cnt_t'(1)) begin
          state_d = StDrain;
        end else begin
          n_d    = n_q + cnt_t'(1);
          addr_d = addr_q + AddressWidth'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      n_q      <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      key_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      key_q    <= key_d;
      result_q <= result_d;
    end
  end

  assign bus.memRead    = (state_q == StRead);
  assign bus.memAddress = addr_q;
  assign bus.busy       = (state_q == StRead) || (state_q == StDrain);
  assign bus.done       = (state_q == StDone);
  assign bus.result     = result_q;

endmodule

// File: tb/tb_heap_array_index.sv
// Directed bench for heap_array_index with a registered-read heap model.
module tb_heap_array_index;
  import heap_pkg::*;

  localparam int NA = HeapNArea;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   done_count;
  logic [HeapElemWidth-1:0] heap_mem [16];

  heap_array_index_if bus ();

  heap_array_index dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Heap model: one-cycle registered read, only on requested reads.
  always @(posedge clock) begin
    if (bus.memRead) bus.memData <= heap_mem[bus.memAddress];
  end

  always @(negedge clock) begin
    if (bus.done) done_count++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Entered just after a negedge; start is taken at the following posedge (E0).
  task automatic run_search(input string name, input int arr, input int sz, input int ky,
                            input int exp_res);
    int k, dc, reads, base;
    k     = (sz > NA) ? NA : sz;
    dc    = (k == 0) ? 1 : k + 2;
    base  = arr * NA;
    reads = 0;
    bus.start = 1'b1;
    bus.array = 12'(arr);
    bus.size  = 12'(sz);
    bus.key   = 12'(ky);
    for (int cyc = 1; cyc <= dc + 1; cyc++) begin
      @(negedge clock);
      if (cyc == 1) bus.start = 1'b0;
      if (bus.memRead) begin
        check($sformatf("%s addr%0d", name, reads), 32'(bus.memAddress), base + reads);
        check($sformatf("%s read cycle%0d", name, reads), cyc, reads + 1);
        reads++;
      end
      check($sformatf("%s busy c%0d", name, cyc), 32'(bus.busy),
            32'((k > 0) && (cyc <= k + 1)));
      check($sformatf("%s done c%0d", name, cyc), 32'(bus.done), 32'(cyc == dc));
      if (bus.done) check($sformatf("%s result", name), 32'(bus.result), exp_res);
    end
    check($sformatf("%s read count", name), reads, k);
    check($sformatf("%s result held", name), 32'(bus.result), exp_res);
  endtask

  initial begin
    int first_done, second_done, b2b_dones, d0;
    clock      = 1'b0;
    reset      = 1'b0;
    n_checks   = 0;
    n_pass     = 0;
    done_count = 0;
    bus.start  = 1'b0;
    bus.array  = '0;
    bus.size   = '0;
    bus.key    = '0;
    bus.memData = '0;
    for (int i = 0; i < 16; i++) heap_mem[i] = 12'(100 + i);
    heap_mem[0] = 12'd10; heap_mem[1] = 12'd20; heap_mem[2] = 12'd30; heap_mem[3] = 12'd5;
    for (int i = 4; i < 8; i++) heap_mem[i] = 12'd7;
    heap_mem[8] = 12'd1; heap_mem[9] = 12'd2; heap_mem[10] = 12'd3; heap_mem[11] = 12'd4;

    #1;
    check("reset busy",    32'(bus.busy),       0);
    check("reset done",    32'(bus.done),       0);
    check("reset result",  32'(bus.result),     0);
    check("reset memRead", 32'(bus.memRead),    0);
    check("reset memAddr", 32'(bus.memAddress), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_search("a0 key20", 0, 3, 20, 2);
    run_search("a0 key99", 0, 3, 99, 0);
    run_search("a1 key7",  1, 4, 7,  4);
    run_search("size0",    0, 0, 10, 0);
    run_search("size9 a2", 2, 9, 3,  3);

    // Back-to-back with start held; inputs changed mid-search must be ignored.
    first_done  = 0;
    second_done = 0;
    b2b_dones   = 0;
    bus.start = 1'b1;
    bus.array = 12'd0;
    bus.size  = 12'd3;
    bus.key   = 12'd20;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clock);
      if (cyc == 2) begin
        bus.array = 12'd1;
        bus.size  = 12'd4;
        bus.key   = 12'd7;
      end
      if (cyc == 7) bus.start = 1'b0;
      if (bus.done) begin
        b2b_dones++;
        if (first_done == 0) begin
          first_done = cyc;
          check("b2b first result", 32'(bus.result), 2);
        end else if (second_done == 0) begin
          second_done = cyc;
          check("b2b second result", 32'(bus.result), 4);
        end
      end
    end
    check("b2b first done cycle",  first_done,  5);
    check("b2b second done cycle", second_done, 12);
    check("b2b done pulses",       b2b_dones,   2);

    // Reset in cycle 2 of a size-4 search.
    bus.start = 1'b1;
    bus.array = 12'd1;
    bus.size  = 12'd4;
    bus.key   = 12'd7;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("pre-reset memRead", 32'(bus.memRead), 1);
    d0 = done_count;
    reset = 1'b0;
    #1;
    check("mid reset memRead", 32'(bus.memRead),    0);
    check("mid reset busy",    32'(bus.busy),       0);
    check("mid reset done",    32'(bus.done),       0);
    check("mid reset result",  32'(bus.result),     0);
    check("mid reset memAddr", 32'(bus.memAddress), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    #1;
    check("no done after reset", done_count, d0);
    @(negedge clock);
    run_search("post reset", 0, 3, 30, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
